// File: rtl/icap_bitstream_writer.sv
// icap_bitstream_writer
//   Initiator for the FPGA internal configuration access port. Takes a partial
//   bitstream as a 32-bit valid/ready word stream and drives the ICAPE2/ICAPE3
//   write interface: session setup, per-byte bit swap, AVAIL back-pressure,
//   PRDONE/PRERROR monitoring and a completion timeout.
//
// Parameters
//   TECH        1 = ICAPE2 (avail/prdone/prerror ignored), otherwise ICAPE3
//   SWAP_BITS   1 = reverse bit order within each byte of s_data
//   TIMEOUT_CYC cycles to wait for PRDONE after the last word (ICAPE3 only)
//
// Ports
//   clk, rstn                  clock (also ICAP clock), sync active-low reset
//   start, num_words           session request pulse and word count
//   s_valid, s_data, s_ready   bitstream word stream
//   busy, done, error          session status; done/error are one-cycle pulses
//   err_code                   00 none, 01 PRERROR, 10 timeout
//   words_sent                 words written to ICAP in current/last session
//   icap_csib, icap_rdwrb,
//   icap_i                     registered ICAP controls and data
//   icap_avail, icap_prdone,
//   icap_prerror               ICAPE3 status inputs
module icap_bitstream_writer #(
  parameter int unsigned TECH        = 1,
  parameter int unsigned SWAP_BITS   = 1,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] num_words,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] words_sent,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic        icap_avail,
  input  logic        icap_prdone,
  input  logic        icap_prerror
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [31:0] remaining;
  logic [23:0] wait_cnt;
  logic        avail_eff;
  logic        prerror_eff;
  logic        prdone_eff;
  logic        handshake;

  assign avail_eff   = (TECH == 1) ? 1'b1 : icap_avail;
  assign prerror_eff = (TECH == 1) ? 1'b0 : icap_prerror;
  assign prdone_eff  = (TECH == 1) ? 1'b0 : icap_prdone;

  // PRERROR blocks acceptance in the same cycle so that no word is taken from
  // upstream that would then be dropped by the abort.
  assign s_ready   = (state == S_WRITE) && avail_eff && (remaining != '0) && !prerror_eff;
  assign handshake = s_valid && s_ready;

  function automatic logic [31:0] swap_word(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (SWAP_BITS == 1) begin
      for (int unsigned k = 0; k < 4; k++) begin
        for (int unsigned j = 0; j < 8; j++) begin
          r[8*k+j] = w[8*k+7-j];
        end
      end
    end
    return r;
  endfunction

  // done/error are raised on the edge that enters FINISH, so the pulse lines up
  // with the single FINISH cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      remaining  <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      words_sent <= '0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_code   <= 2'b00;
            words_sent <= '0;
            if (num_words == '0) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              remaining <= num_words;
              busy      <= 1'b1;
              state     <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          // csib is high here, so RDWRB can switch to write safely.
          icap_rdwrb <= 1'b0;
          state      <= S_WRITE;
        end

        S_WRITE: begin
          if (prerror_eff) begin
            icap_csib <= 1'b1;
            err_code  <= 2'b01;
            error     <= 1'b1;
            state     <= S_FINISH;
          end else if (handshake) begin
            icap_i    <= swap_word(s_data);
            icap_csib <= 1'b0;
            remaining <= remaining - 32'd1;
            if (words_sent != '1) begin
              words_sent <= words_sent + 32'd1;
            end
            if (remaining == 32'd1) begin
              wait_cnt <= '0;
              state    <= S_WAIT_DONE;
            end
          end else begin
            icap_csib <= 1'b1;
          end
        end

        S_WAIT_DONE: begin
          icap_csib <= 1'b1;
          if (TECH == 1) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (prerror_eff) begin
            err_code <= 2'b01;
            error    <= 1'b1;
            state    <= S_FINISH;
          end else if (prdone_eff) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            err_code <= 2'b10;
            error    <= 1'b1;
            state    <= S_FINISH;
          end else begin
            wait_cnt <= wait_cnt + 24'd1;
          end
        end

        S_FINISH: begin
          icap_rdwrb <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_bitstream_writer.sv
module tb_icap_bitstream_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_words = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] words_sent;
  logic        icap_csib, icap_rdwrb;
  logic [31:0] icap_i;
  logic        icap_avail = 1'b1;
  logic        icap_prdone = 1'b0;
  logic        icap_prerror = 1'b0;

  logic        t1_start = 1'b0;
  logic [31:0] t1_num_words = '0;
  logic        t1_s_valid = 1'b0;
  logic [31:0] t1_s_data = '0;
  logic        t1_s_ready, t1_busy, t1_done, t1_error;
  logic [1:0]  t1_err_code;
  logic [31:0] t1_words_sent;
  logic        t1_csib, t1_rdwrb;
  logic [31:0] t1_icap_i;

  icap_bitstream_writer #(.TECH(0), .SWAP_BITS(1), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_words(num_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .words_sent(words_sent), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
    .icap_i(icap_i), .icap_avail(icap_avail), .icap_prdone(icap_prdone),
    .icap_prerror(icap_prerror)
  );

  icap_bitstream_writer #(.TECH(1), .SWAP_BITS(0), .TIMEOUT_CYC(16)) dut1 (
    .clk(clk), .rstn(rstn), .start(t1_start), .num_words(t1_num_words),
    .s_valid(t1_s_valid), .s_data(t1_s_data), .s_ready(t1_s_ready),
    .busy(t1_busy), .done(t1_done), .error(t1_error), .err_code(t1_err_code),
    .words_sent(t1_words_sent), .icap_csib(t1_csib), .icap_rdwrb(t1_rdwrb),
    .icap_i(t1_icap_i), .icap_avail(1'b0), .icap_prdone(1'b0),
    .icap_prerror(1'b1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         words;
    int         at;
  } res_t;

  logic [31:0] exp_words[$];
  res_t        exp_res[$];
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Reference swap: reverse the whole word, then restore byte order.
  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    logic [31:0] t;
    logic [31:0] r;
    t = {<<{w}};
    r = {<<8{t}};
    return r;
  endfunction

  // Monitor: words on the ICAP pins, csib timing, stall behaviour, pulses.
  bit prev_hs = 1'b0;
  bit prev_rstn = 1'b0;
  bit prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("csib_timing", 32'(icap_csib), 32'(!(prev_hs && prev_rstn)));
      if (!icap_csib) begin
        chk("rdwrb_during_write", 32'(icap_rdwrb), 32'd0);
        chk("busy_during_write", 32'(busy), 32'd1);
        if (exp_words.size() == 0) fail_now("icap_word_unexpected");
        else chk("icap_i", icap_i, exp_words.pop_front());
      end
      if (!icap_avail) chk("stall_ready", 32'(s_ready), 32'd0);
      if (prev_pulse) chk("busy_after_pulse", 32'(busy), 32'd0);
      if (done || error) begin
        if (exp_res.size() == 0) fail_now("pulse_unexpected");
        else begin
          res_t r;
          r = exp_res.pop_front();
          chk("pulse_error", 32'(error), 32'(r.is_err));
          chk("pulse_done", 32'(done), 32'(!r.is_err));
          chk("err_code", 32'(err_code), 32'(r.code));
          chk("words_sent", words_sent, 32'(r.words));
          chk("pulse_cycle", 32'(cyc), 32'(r.at));
        end
      end
      prev_pulse = done || error;
      prev_hs    = s_valid && s_ready;
      prev_rstn  = rstn;
    end
  end

  // mode: 0 prdone after d, 1 prerror after d, 2 timeout,
  //       3 prerror during WRITE after k words, 4 reset after k words
  task automatic run_session(input int n, input int mode, input int param,
                             input bit fixed, input bit rnd, input int stall_at);
    logic [31:0] w[$];
    int   sent, c_last, stall_left, guard, n_exp;
    bit   injected;
    res_t r;
    for (int i = 0; i < n; i++) w.push_back(fixed ? 32'h01020304 + 32'(i) * 32'h04040404 : $urandom);
    n_exp = (mode >= 3) ? param : n;
    for (int i = 0; i < n_exp; i++) exp_words.push_back(ref_swap(w[i]));

    @(posedge clk); #1;
    start = 1'b1;
    num_words = 32'(n);
    if (n == 0) begin
      r = '{1'b0, 2'b00, 0, cyc + 1};
      exp_res.push_back(r);
    end
    @(posedge clk); #1;
    start = 1'b0;
    num_words = $urandom;

    sent = 0; c_last = 0; stall_left = 3; guard = 0; injected = 1'b0;
    while (n > 0) begin
      if (mode == 3 && sent == param) begin
        s_valid = 1'b0;
        icap_prerror = 1'b1;
        r = '{1'b1, 2'b01, param, cyc + 1};
        exp_res.push_back(r);
        @(negedge clk);
        chk("abort_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        icap_prerror = 1'b0;
        break;
      end
      if (mode == 4 && sent == param) begin
        s_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_csib", 32'(icap_csib), 32'd1);
        chk("rst_rdwrb", 32'(icap_rdwrb), 32'd1);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words_sent", words_sent, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        break;
      end
      if (sent == n) begin
        s_valid = 1'b0;
        icap_avail = 1'b1;
        // Entry into WAIT_DONE happened on the edge after the last accept.
        if (mode == 2) begin
          r = '{1'b1, 2'b10, n, c_last + 1 + 16};
          exp_res.push_back(r);
        end else begin
          for (int d = 0; d < param; d++) begin @(posedge clk); #1; end
          r = '{(mode == 1), (mode == 1) ? 2'b01 : 2'b00, n, cyc + 1};
          exp_res.push_back(r);
          if (mode == 1) icap_prerror = 1'b1; else icap_prdone = 1'b1;
          @(posedge clk); #1;
          icap_prerror = 1'b0;
          icap_prdone = 1'b0;
        end
        break;
      end
      if (sent == 1 && !injected) begin
        start = 1'b1;
        num_words = 32'd7;
        injected = 1'b1;
      end
      s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = w[sent];
      if (stall_at >= 0 && sent == stall_at && stall_left > 0) begin
        icap_avail = 1'b0;
        stall_left--;
      end else begin
        icap_avail = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (s_valid && s_ready) begin
        sent++;
        c_last = cyc;
      end
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (guard > 2000) begin
        fail_now("write_phase_timeout");
        break;
      end
    end
    s_valid = 1'b0;
    icap_avail = 1'b1;

    for (int g = 0; g < 60 && exp_res.size() != 0; g++) begin @(posedge clk); #1; end
    if (exp_res.size() != 0) begin
      fail_now("pulse_timeout");
      exp_res.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_tech1();
    logic [31:0] w1[3];
    int acc, last, pend;
    bit got;
    for (int i = 0; i < 3; i++) w1[i] = $urandom;
    @(posedge clk); #1;
    t1_start = 1'b1;
    t1_num_words = 32'd3;
    @(posedge clk); #1;
    t1_start = 1'b0;
    t1_s_valid = 1'b1;
    t1_s_data = w1[0];
    acc = 0; last = 0; pend = -1; got = 1'b0;
    for (int g = 0; g < 40 && !got; g++) begin
      @(negedge clk);
      if (pend >= 0) begin
        chk("t1_csib", 32'(t1_csib), 32'd0);
        chk("t1_icap_i", t1_icap_i, w1[pend]);
        pend = -1;
      end
      if (t1_done || t1_error) begin
        chk("t1_done", 32'(t1_done), 32'd1);
        chk("t1_err_code", 32'(t1_err_code), 32'd0);
        chk("t1_words_sent", t1_words_sent, 32'd3);
        chk("t1_done_cycle", 32'(cyc), 32'(last + 2));
        got = 1'b1;
      end
      if (t1_s_valid && t1_s_ready) begin
        pend = acc;
        acc++;
        last = cyc;
      end
      @(posedge clk); #1;
      t1_s_valid = (acc < 3);
      t1_s_data = (acc < 3) ? w1[acc] : '0;
    end
    if (!got) fail_now("t1_done_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mode, param;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_csib", 32'(icap_csib), 32'd1);
    chk("reset_rdwrb", 32'(icap_rdwrb), 32'd1);
    chk("reset_icap_i", icap_i, 32'd0);
    chk("reset_ready", 32'(s_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    chk("reset_words_sent", words_sent, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    mon_en = 1'b1;

    run_session(4, 0, 10, 1'b1, 1'b0, -1);
    run_session(6, 0, 3, 1'b0, 1'b0, 2);
    run_session(8, 3, 3, 1'b0, 1'b0, -1);
    run_session(5, 2, 0, 1'b0, 1'b1, -1);
    run_session(0, 0, 0, 1'b0, 1'b0, -1);
    run_session(6, 0, 15, 1'b0, 1'b1, -1);
    run_session(8, 4, 4, 1'b0, 1'b0, -1);
    run_session(5, 0, 2, 1'b0, 1'b0, -1);
    run_session(3, 1, 5, 1'b0, 1'b1, -1);
    for (int s = 0; s < 12; s++) begin
      n = $urandom_range(1, 12);
      mode = $urandom_range(0, 3);
      if (mode == 3 && n < 2) mode = 0;
      param = (mode == 3) ? $urandom_range(1, n - 1) : $urandom_range(0, 15);
      run_session(n, mode, param, 1'b0, 1'b1, (s % 3 == 0) ? $urandom_range(0, n - 1) : -1);
    end

    run_tech1();

    repeat (3) @(posedge clk);
    chk("words_drained", 32'(exp_words.size()), 32'd0);
    chk("results_drained", 32'(exp_res.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
